mac_stop_engine: RTL
====================

MAC_STOP_ENGINE -- requirements
Module: mac_stop_engine

Interface
REQ-001 SHALL have parameter M, default 4: rows of A and C (min 2).
REQ-002 SHALL have parameter K, default 4: columns of A and rows of B (min 2).
REQ-003 SHALL have parameter N, default 4: columns of B and C (min 2).
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX (DW), default 32: A/B element width.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX (RW), default 2*DW+clog2(K): C element width.
REQ-006 SHALL have port clk, input, 1: clock, rising edge.
REQ-007 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: begin C = A x B.
REQ-009 SHALL have port stop, input, 1: abort the current run.
REQ-010 SHALL have port busy, output, 1: run in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the run completes.
REQ-012 SHALL have port aborted, output, 1: one-cycle pulse when stop ends a run.
REQ-013 SHALL have ports row_addr_a/col_addr_a, outputs, clog2(M)/clog2(K): A read address.
REQ-014 SHALL have ports row_addr_b/col_addr_b, outputs, clog2(K)/clog2(N): B read address.
REQ-015 SHALL have ports row_addr_c/col_addr_c, outputs, clog2(M)/clog2(N): C write address.
REQ-016 SHALL have ports matrix_a_re/matrix_b_re, outputs, 1: read enables to the matrix memory.
REQ-017 SHALL have port matrix_c_we, output, 1: write enable to the matrix memory.
REQ-018 SHALL have ports data_in_a/data_in_b, inputs, DW: same-cycle (asynchronous) read data from the memory.
REQ-019 SHALL have port data_out_c, output, RW: C write data.

Function
REQ-020 SHALL implement a 4-state FSM: IDLE, MAC, WRITE, DONE.
REQ-021 SHALL, in IDLE, move to MAC on start=1 and stop=0, with counters i=j=k=0 and acc=0.
REQ-022 SHALL, in MAC: drive a_re=b_re=1, A addr (i,k), B addr (k,j); at the edge set acc += data_in_a*data_in_b.
REQ-023 SHALL, in MAC, increment k each cycle; after the k=K-1 cycle, set k to 0 and go to WRITE.
REQ-024 SHALL, in WRITE: drive c_we=1, C addr (i,j), data_out_c=acc for exactly one cycle; then clear acc.
REQ-025 SHALL, after WRITE, advance j, and on the j=N-1 wrap advance i, then return to MAC.
REQ-026 SHALL, after WRITE of element (M-1,N-1), enter DONE.
REQ-027 SHALL, in DONE, assert done=1 for one cycle and then go to IDLE.
REQ-028 SHALL take exactly M*N*(K+1) cycles from the start-accepting edge to the final write; done follows in the next cycle.
REQ-029 SHALL compute products unsigned at 2*DW bits, zero-extend them to RW, and accumulate modulo 2^RW.
REQ-030 SHALL assert busy in MAC and WRITE only.
REQ-031 SHALL drive re/we 0 outside MAC/WRITE, and drive addresses and data_out_c 0 in IDLE.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL keep the FSM in IDLE when start=1 and stop=1 in IDLE; stop wins and aborted stays 0.
REQ-034 SHALL respond to stop=1 while busy by gating matrix_c_we to 0 that cycle, going to IDLE at the edge, and pulsing aborted=1 the next cycle.
REQ-035 SHALL ignore stop in IDLE and DONE; stop in DONE does not suppress done.

Reset
REQ-036 SHALL, while resetn=0 (asynchronous), force state IDLE; i, j, k, acc = 0; and every output 0.
REQ-037 SHALL, on reset during a run, leave no partial write pending; the next run requires a fresh start.

Verification (M=K=N=2, DW=8, RW=17)
REQ-038 SHALL cover: A=identity, B=[[1,2],[3,4]], start -> C writes (0,0)=1,(0,1)=2,(1,0)=3,(1,1)=4 in order; done 13 cycles after start.
REQ-039 SHALL cover: all A,B=255 -> every C write = 130050, no truncation.
REQ-040 SHALL cover: stop during cycle 5 (the second WRITE) -> no c_we that cycle or later; aborted pulse; busy=0; exactly one C write.
REQ-041 SHALL cover: start reasserted mid-run -> no effect; start+stop in IDLE -> stays IDLE, busy=0.
REQ-042 SHALL cover: resetn low during MAC -> all outputs 0 immediately; no writes until a new start.
REQ-043 SHALL cover: start in the cycle after done -> second run produces identical results and timing.

Source files
------------

// File: rtl/mac_stop_engine.sv
// Matrix multiply engine C = A x B reading A/B elements from an external
// memory with same-cycle read data and writing each C element once.
// The run walks C in row-major order: K multiply-accumulate cycles per element
// followed by one write cycle, then a single-cycle done pulse.
// A stop while busy abandons the run, suppresses any write in that cycle and
// pulses aborted in the following cycle.
//
// Handshake: start is sampled only in IDLE and is accepted when stop is low;
// the run then owns the memory ports until done or aborted is pulsed. Read
// enables are high in every MAC cycle, and data_in_a/data_in_b must be valid
// in that same cycle. matrix_c_we is high for exactly one cycle per C element,
// with the address and data_out_c valid in that cycle.
module mac_stop_engine #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic                                stop,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic [$clog2(M)-1:0]                row_addr_a,
    output logic [$clog2(K)-1:0]                col_addr_a,
    output logic [$clog2(K)-1:0]                row_addr_b,
    output logic [$clog2(N)-1:0]                col_addr_b,
    output logic [$clog2(M)-1:0]                row_addr_c,
    output logic [$clog2(N)-1:0]                col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_we,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c
);

    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int AM = $clog2(M);
    localparam int AK = $clog2(K);
    localparam int AN = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [AM-1:0]  i_q;
    logic [AN-1:0]  j_q;
    logic [AK-1:0]  k_q;
    logic [RW-1:0]  acc_q;
    logic           aborted_q;

    logic           last_i;
    logic           last_j;
    logic           last_k;
    logic           abort_req;
    logic [2*DW-1:0] product;

    assign last_i    = (i_q == AM'(M - 1));
    assign last_j    = (j_q == AN'(N - 1));
    assign last_k    = (k_q == AK'(K - 1));
    assign abort_req = stop && ((state == S_MAC) || (state == S_WRITE));
    // Full-width unsigned product; it is zero-extended into the accumulator.
    assign product   = data_in_a * data_in_b;
    assign aborted   = aborted_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and memory-side outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        row_addr_a  = '0;
        col_addr_a  = '0;
        row_addr_b  = '0;
        col_addr_b  = '0;
        row_addr_c  = '0;
        col_addr_c  = '0;
        data_out_c  = '0;
        case (state)
            S_IDLE: begin
                // stop outranks start so a simultaneous request never launches.
                if (start && !stop) state_next = S_MAC;
            end
            S_MAC: begin
                busy        = 1'b1;
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                row_addr_a  = i_q;
                col_addr_a  = k_q;
                row_addr_b  = k_q;
                col_addr_b  = j_q;
                if (stop)        state_next = S_IDLE;
                else if (last_k) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                // A stop in the write cycle must not commit a partial result.
                matrix_c_we = !stop;
                row_addr_c  = i_q;
                col_addr_c  = j_q;
                data_out_c  = acc_q;
                if (stop)                 state_next = S_IDLE;
                else if (last_i && last_j) state_next = S_DONE;
                else                      state_next = S_MAC;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Element counters, accumulator and the delayed abort pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req;
            case (state)
                S_MAC: begin
                    if (stop) begin
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end else begin
                        acc_q <= acc_q + RW'(product);
                        k_q   <= last_k ? '0 : k_q + AK'(1);
                    end
                end
                S_WRITE: begin
                    acc_q <= '0;
                    k_q   <= '0;
                    if (stop) begin
                        i_q <= '0;
                        j_q <= '0;
                    end else if (last_j) begin
                        j_q <= '0;
                        i_q <= last_i ? '0 : i_q + AM'(1);
                    end else begin
                        j_q <= j_q + AN'(1);
                    end
                end
                default: begin
                    i_q   <= '0;
                    j_q   <= '0;
                    k_q   <= '0;
                    acc_q <= '0;
                end
            endcase
        end
    end

endmodule
